riscv_multicycle: RTL and testbench

- Parametrised multi-cycle RV32I-subset core. Next generation of the single-cycle core.
- Shares one FSM-sequenced datapath (ALU, register file, immediate generator) across instruction phases.
- Talks to external instruction and data memories over req/ack handshakes, so wait-state memories are supported.
- Sits at SoC top level between the memory subsystem and debug/trace outputs.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/riscv_multicycle_alu.sv | 25 ++
 rtl/riscv_multicycle.sv | 131 +++++++++++++
 tb/tb_riscv_multicycle.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, funct fields, ALU/FSM enums and decode helpers for the multicycle core
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_e;
  // SYSTEM (ECALL) is deliberately not legal so it lands in HALT
  function automatic logic legal(input logic [31:0] ir);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    case (ir[6:0])
      OP_R:              legal = (f7 == F7_BASE && f3 != F3_SLTU) || (f7 == F7_ALT && f3 == F3_ADD);
      OP_I:              legal = f3 inside {F3_ADD, F3_AND, F3_OR, F3_SLT};
      OP_LOAD, OP_STORE: legal = f3 == F3_LW;
      OP_BRANCH:         legal = f3 inside {F3_BEQ, F3_BNE};
      OP_JAL:            legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  endfunction
  function automatic alu_op_e alu_sel(input logic [31:0] ir);
    logic arith;
    arith = ir[6:0] == OP_R || ir[6:0] == OP_I;
    case (ir[14:12])
      F3_ADD:  alu_sel = (ir[6:0] == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_sel = ALU_SLL;
      F3_SLT:  alu_sel = ALU_SLT;
      F3_XOR:  alu_sel = ALU_XOR;
      F3_SRL:  alu_sel = ALU_SRL;
      F3_OR:   alu_sel = ALU_OR;
      F3_AND:  alu_sel = ALU_AND;
      default: alu_sel = ALU_ADD;
    endcase
    if (!arith) alu_sel = ALU_ADD;
  endfunction
endpackage

// File: rtl/riscv_multicycle_alu.sv
// rv_alu: combinational ALU shared by all instruction phases
module rv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] y_o
);
  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLL: y_o = a_i << b_i[4:0];
      ALU_SRL: y_o = a_i >> b_i[4:0];
      default: ;
    endcase
  end
endmodule

// File: rtl/riscv_multicycle.sv
// riscv_multicycle: FSM-sequenced RV32I-subset core with req/ack instruction and data memories
module riscv_multicycle
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            halted
);
  localparam int AW = $clog2(NREGS);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, aluout_q, aluout_d, mdr_q, mdr_d;
  logic [31:0] ir_q, ir_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [6:0] opcode;
  logic [AW-1:0] rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_y, pc_plus4, pc_imm, wb_data;
  logic signed [31:0] imm32;
  logic taken, rf_we;
  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[7 +: AW];
  assign rs1      = ir_q[15 +: AW];
  assign rs2      = ir_q[20 +: AW];
  assign rs1_val  = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_val  = (rs2 == '0) ? '0 : rf_q[rs2];
  assign imm32    = (opcode == OP_STORE)  ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]} :
                    (opcode == OP_BRANCH) ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0} :
                    (opcode == OP_JAL)    ? {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0} :
                                            {{20{ir_q[31]}}, ir_q[31:20]};
  assign alu_b    = (opcode == OP_R) ? b_q : imm_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign pc_imm   = pc_q + imm_q;
  assign taken    = ir_q[12] ? (a_q != b_q) : (a_q == b_q);
  assign wb_data  = (opcode == OP_LOAD) ? mdr_q : aluout_q;
  rv_alu #(.XLEN(XLEN)) u_alu (
    .a_i (a_q),
    .b_i (alu_b),
    .op_i(alu_sel(ir_q)),
    .y_o (alu_y)
  );
  // requests drop combinationally while reset is held
  assign imem_req   = !reset && state_q == S_FETCH;
  assign imem_addr  = pc_q;
  assign dmem_req   = !reset && state_q == S_MEM;
  assign dmem_we    = dmem_req && opcode == OP_STORE;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = b_q;
  assign pc_out     = pc_q;
  assign instr_out  = ir_q;
  assign halted     = !reset && state_q == S_HALT;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_ack ? imem_rdata : ir_q;
        state_d = imem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        imm_d   = XLEN'(imm32);
        state_d = legal(ir_q) ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        aluout_d = (opcode == OP_JAL) ? pc_plus4 : alu_y;
        pc_d     = (opcode == OP_JAL) ? pc_imm :
                   (opcode == OP_BRANCH) ? (taken ? pc_imm : pc_plus4) : pc_q;
        state_d  = (opcode == OP_BRANCH) ? S_FETCH :
                   (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mdr_d   = (dmem_ack && opcode == OP_LOAD) ? dmem_rdata : mdr_q;
        pc_d    = (dmem_ack && opcode == OP_STORE) ? pc_plus4 : pc_q;
        state_d = !dmem_ack ? S_MEM : (opcode == OP_STORE) ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we   = rd != '0;
        pc_d    = (opcode == OP_JAL) ? pc_q : pc_plus4;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[rd] <= wb_data;
  end
endmodule

// File: tb/tb_riscv_multicycle.sv
// tb_riscv_multicycle: directed programs with a data-memory transaction scoreboard
module tb_riscv_multicycle;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out, instr_out;
  logic [31:0] imem [64];
  int          dwait = 0;
  int          dcnt = 0;
  logic        dack_force = 1'b0;
  int          checks = 0;
  int          fails = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  txn_t sb[$];
  localparam logic [31:0] ECALL = 32'h00000073;

  riscv_multicycle dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = dack_force || (dmem_req && dcnt == dwait);
  assign dmem_rdata = 32'hDEADBEEF;
  always @(posedge clk) dcnt <= (reset || !dmem_req) ? 0 : dcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    sb.push_back(t);
  endtask

  // one cycle; any data request seen is scored against the queue head
  task automatic cyc();
    @(negedge clk);
    if (dmem_req) begin
      checks++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_extra observed=req@%h expected=none", dmem_addr);
      end
      if (sb.size() > 0) begin
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, sb[0].we});
        chk("dmem_addr", dmem_addr, sb[0].addr);
        if (dmem_ack) begin
          if (sb[0].we) chk("dmem_wdata", dmem_wdata, sb[0].wdata);
          void'(sb.pop_front());
        end
      end
    end
  endtask

  task automatic run_to(input logic [31:0] pc, input int n, input string tag);
    int k;
    bit hit;
    k = 0;
    hit = 0;
    while (!hit && k < 100) begin
      cyc();
      k++;
      hit = imem_req && pc_out == pc;
    end
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_cycles"}, k, n);
  endtask

  task automatic chk_halt(input logic [31:0] pc, input string tag);
    repeat (2) cyc();
    chk({tag, "_halted"}, {31'b0, halted}, 32'd1);
    chk({tag, "_noreq"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_pc"}, pc_out, pc);
    repeat (3) cyc();
    chk({tag, "_still_noreq"}, {31'b0, imem_req}, 32'd0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = ECALL;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // program 1: ALU ops, waited load, stores, x0 writes, JAL, ECALL
    clear_prog();
    imem[0]  = 32'h00500093;
    imem[1]  = 32'h00700113;
    imem[2]  = 32'h002081B3;
    imem[3]  = 32'h00402203;
    imem[4]  = 32'h00302423;
    imem[5]  = 32'h00402623;
    imem[6]  = 32'h00900013;
    imem[7]  = 32'h00002823;
    imem[8]  = 32'h0100006F;
    imem[12] = 32'h00002A23;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ir", instr_out, 32'h0);
    reset = 1'b0;
    push(1'b0, 32'd4, 32'd0);
    push(1'b1, 32'd8, 32'd12);
    push(1'b1, 32'd12, 32'hDEADBEEF);
    push(1'b1, 32'd16, 32'd0);
    push(1'b1, 32'd20, 32'd0);
    run_to(32'h0C, 12, "alu3");
    chk("ir_add", instr_out, 32'h002081B3);
    dwait = 3;
    run_to(32'h10, 8, "lw_wait");
    dwait = 0;
    run_to(32'h14, 4, "sw_x3");
    run_to(32'h18, 4, "sw_x4");
    run_to(32'h1C, 4, "addi_x0");
    run_to(32'h20, 4, "sw_x0");
    run_to(32'h30, 4, "jal");
    run_to(32'h34, 4, "sw_x0_jal");
    chk_halt(32'h34, "ecall");
    chk("sb_empty", sb.size(), 32'd0);
    // program 2: taken BEQ backwards
    clear_prog();
    imem[0] = 32'h00500093;
    imem[1] = 32'h00C0006F;
    imem[4] = 32'hFE108CE3;
    do_reset();
    run_to(32'h04, 4, "p2_addi");
    run_to(32'h10, 4, "p2_jal");
    run_to(32'h08, 3, "beq_taken");
    chk_halt(32'h08, "p2_halt");
    // program 3: BNE with equal operands falls through
    imem[4] = 32'hFE109CE3;
    do_reset();
    run_to(32'h04, 4, "p3_addi");
    run_to(32'h10, 4, "p3_jal");
    run_to(32'h14, 3, "bne_fall");
    chk_halt(32'h14, "p3_halt");
    // program 4: reset while a load waits, ack arrives after reset
    clear_prog();
    imem[0] = 32'h00402203;
    do_reset();
    dwait = 20;
    push(1'b0, 32'd4, 32'd0);
    repeat (4) cyc();
    chk("mid_mem_req", {31'b0, dmem_req}, 32'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("rst_drop_dmem", {31'b0, dmem_req}, 32'd0);
    chk("rst_drop_imem", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dack_force = 1'b1;
    dwait = 0;
    push(1'b0, 32'd4, 32'd0);
    #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    cyc();
    dack_force = 1'b0;
    run_to(32'h04, 4, "late_ack");
    chk_halt(32'h04, "p4_halt");
    chk("sb_empty_end", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
